// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the shared-adder arbiter.
package adder_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Upper bounds used to size the generic round-robin helper.
    localparam int MAX_NREQ = 8;
    localparam int MAX_IDW  = 3;

    // Index width for a requester count. It is never narrower than one bit,
    // so a zero-width id field cannot appear.
    function automatic int idw_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Round-robin pick. It scans ptr, ptr+1, ... modulo n and returns {found, index}.
    // The loop runs downwards, so the smallest offset from ptr writes last and wins.
    function automatic logic [MAX_IDW:0] rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input logic [MAX_IDW-1:0]  ptr,
        input int                  n
    );
        logic [MAX_IDW:0] res;
        int               idx;
        res = '0;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (valid[idx]) begin
                    res = {1'b1, idx[MAX_IDW-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin grant for the shared adder.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            found_o
);

    logic [MAX_IDW:0] pick;

    // Search starts at ptr_i. Requesters are skipped entirely when the arbiter is not enabled.
    always_comb begin
        pick    = rr_pick(MAX_NREQ'(valid_i), MAX_IDW'(ptr_i), NREQ);
        found_o = en_i & pick[MAX_IDW];
        idx_o   = pick[IDW-1:0];
    end

    // Expand the index into a one-hot grant vector.
    // At most one bit can be high because only one index is ever selected.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant_o[gi] = found_o && (idx_o == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/adder_share_arbiter.sv
// One W+1-bit adder shared by NREQ requesters.
// Selection is round-robin, and the registered result uses valid/ready handshakes.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [W-1:0]              res_sum,
    output logic                      res_carry,
    output logic [idw_of(NREQ)-1:0]   res_id,
    output logic                      busy
);

    localparam int IDW = idw_of(NREQ);

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic            res_valid_q;
    logic [W-1:0]    res_sum_q;
    logic            res_carry_q;
    logic [IDW-1:0]  res_id_q;

    logic            acc;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            found;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [W:0]      sum_d;

    // A new operand pair may enter when nothing is held, or when the held result leaves this cycle.
    // Reset blocks every handshake.
    assign acc = (state_q == IDLE) | ((state_q == HOLD) & res_ready);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (acc & ~rst),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .found_o (found)
    );

    assign req_ready = grant;

    // The one-hot grant drives an AND-OR operand mux. No operand bit reaches req_ready.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_sel = a_sel | (req_a[i*W +: W] & {W{grant[i]}});
            b_sel = b_sel | (req_b[i*W +: W] & {W{grant[i]}});
        end
    end

    // This is the single shared adder. Its carry out is the top bit.
    assign sum_d = {1'b0, a_sel} + {1'b0, b_sel};

    // After a grant, the pointer moves to the requester just past the winner.
    assign ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // FSM, round-robin pointer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            res_id_q    <= '0;
        end else if (found) begin
            state_q     <= HOLD;
            ptr_q       <= ptr_d;
            res_valid_q <= 1'b1;
            {res_carry_q, res_sum_q} <= sum_d;
            res_id_q    <= grant_idx;
        end else if ((state_q == HOLD) && res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign busy      = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_carry = res_carry_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter.
// It uses table-driven single transfers, directed corner sequences and a random phase.
// All of them are checked against a transaction-level model.
module tb_adder_share_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_carry;
    logic [0:0]        res_id;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: the held result and the requester that has the next turn.
    bit      m_held;
    int      m_sum;
    int      m_carry;
    int      m_id;
    int      m_ptr;
    int      last_grant;

    adder_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which requester the turn order favours right now, or -1 if none may be accepted.
    function automatic int model_grant();
        if (rst) return -1;
        if (m_held && !res_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock. Check outputs at the falling edge, then advance the model at the rising edge.
    // Inputs are then free to change 1 time unit later.
    task automatic cycle();
        int g;
        int s;
        @(negedge clk);
        g = model_grant();
        check("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
        check("res_valid", int'(res_valid), int'(m_held));
        check("busy", int'(busy), int'(m_held));
        if (m_held || rst) begin
            check("res_sum", int'(res_sum), m_sum);
            check("res_carry", int'(res_carry), m_carry);
            check("res_id", int'(res_id), m_id);
        end
        @(posedge clk);
        last_grant = g;
        if (rst) begin
            m_held = 0; m_ptr = 0; m_sum = 0; m_carry = 0; m_id = 0;
        end else if (g >= 0) begin
            s       = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
            m_sum   = s % (1 << W);
            m_carry = s / (1 << W);
            m_id    = g;
            m_held  = 1;
            m_ptr   = (g + 1) % NREQ;
            $display("xfer id=%0d a=%02h b=%02h -> sum=%02h carry=%0d",
                     g, req_a[g*W +: W], req_b[g*W +: W], m_sum, m_carry);
        end else if (m_held && res_ready) begin
            m_held = 0;
        end
        #1;
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        logic       exp_carry;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int cnt[NREQ];
        int prev_id;
        logic [7:0] saved_sum;

        tbl[0] = '{0, 8'h12, 8'h34, 8'h46, 1'b0};
        tbl[1] = '{1, 8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[2] = '{1, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        tbl[3] = '{0, 8'h80, 8'h80, 8'h00, 1'b1};
        tbl[4] = '{1, 8'h00, 8'h00, 8'h00, 1'b0};

        m_held = 0; m_ptr = 0; m_sum = 0; m_carry = 0; m_id = 0;

        // Reset with every requester asserting.
        rst = 1'b1; req_valid = '1; res_ready = 1'b1;
        req_a = 16'h5566; req_b = 16'h7788;
        cycle();
        cycle();
        rst = 1'b0; req_valid = '0;
        cycle();

        // Single transfers from the table. The result appears one cycle after the grant.
        foreach (tbl[t]) begin
            req_valid = '0;
            req_valid[tbl[t].id] = 1'b1;
            req_a[tbl[t].id*W +: W] = tbl[t].a;
            req_b[tbl[t].id*W +: W] = tbl[t].b;
            cycle();
            req_valid = '0;
            check("tbl_sum", int'(res_sum), int'(tbl[t].exp_sum));
            check("tbl_carry", int'(res_carry), int'(tbl[t].exp_carry));
            check("tbl_id", int'(res_id), tbl[t].id);
            cycle();
        end
        cycle();

        // Both requesters stay valid. Grants must alternate with no bubbles.
        cnt = '{default: 0};
        prev_id = -1;
        req_valid = '1; res_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cycle();
            if (last_grant >= 0) cnt[last_grant]++;
            check("stream_valid", int'(res_valid), 1);
            if (prev_id >= 0) check("alternate", int'(res_id), 1 - prev_id);
            prev_id = int'(res_id);
            req_a[res_id*W +: W] = W'($urandom);
            req_b[res_id*W +: W] = W'($urandom);
        end
        check("fair0", cnt[0], 4);
        check("fair1", cnt[1], 4);

        // Backpressure in HOLD. Outputs stay frozen and no request is accepted.
        res_ready = 1'b0;
        saved_sum = res_sum;
        for (int n = 0; n < 3; n++) begin
            cycle();
            check("bp_sum_stable", int'(res_sum), int'(saved_sum));
            check("bp_held", int'(res_valid), 1);
        end
        res_ready = 1'b1;
        cycle();
        check("bp_release_valid", int'(res_valid), 1);

        // Reset while holding id=1 with ptr=0. After reset, requester 0 must be granted first.
        req_valid = 2'b10;
        cycle();
        check("pre_rst_id", int'(res_id), 1);
        rst = 1'b1; res_ready = 1'b0; req_valid = '0;
        cycle();
        check("post_rst_valid", int'(res_valid), 0);
        rst = 1'b0; res_ready = 1'b1; req_valid = 2'b11;
        @(negedge clk);
        check("post_rst_grant", int'(req_ready), 1);
        @(posedge clk); #1;
        m_held = 1; m_id = 0; m_ptr = 1;
        m_sum = (int'(req_a[0 +: W]) + int'(req_b[0 +: W])) % (1 << W);
        m_carry = (int'(req_a[0 +: W]) + int'(req_b[0 +: W])) / (1 << W);
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_a     = (NREQ*W)'($urandom);
            req_b     = (NREQ*W)'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
